snake_led_fx: RTL and testbench



---
 rtl/snake_led_pkg.sv | 11 +
 rtl/snake_led_tick.sv | 21 ++
 rtl/snake_led_fx.sv | 82 ++++++++
 tb/tb_snake_led_fx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/snake_led_pkg.sv
// snake_led_pkg: shared constants, FSM state type and width helper for the LED effects block
package snake_led_pkg;
  localparam int LED_W_DEF = 10;
  typedef enum logic {ST_IDLE = 1'b0, ST_FLASH = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/snake_led_tick.sv
// snake_led_tick: blink-phase prescaler, one-cycle tick every TICK_DIV cycles, restartable
module snake_led_tick
  import snake_led_pkg::*;
#(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int TW = clog2(TICK_DIV);
  localparam logic [TW-1:0] TOP = TW'(TICK_DIV - 1);
  logic [TW-1:0] r_cnt;
  assign o_tick = r_cnt == TOP;
  // Count 0..TICK_DIV-1; a clear restarts so the next phase is a full period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else r_cnt <= (i_clr || o_tick) ? '0 : r_cnt + TW'(1);
  end
endmodule

// File: rtl/snake_led_fx.sv
// snake_led_fx: blinks changed LED bits a fixed number of times, then applies global PWM dimming
module snake_led_fx
  import snake_led_pkg::*;
#(
  parameter int LED_W    = LED_W_DEF,
  parameter int TICK_DIV = 5000000,
  parameter int BLINKS   = 3,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [LED_W-1:0]    led_word_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [LED_W-1:0]    led_out,
  output logic                flashing
);
  localparam int PW = clog2(2 * BLINKS);
  localparam logic [PW-1:0] LAST = PW'(2 * BLINKS - 1);
  state_t r_state, w_state_nx;
  logic [LED_W-1:0] r_word_q, r_mask, w_mask_nx, w_chg, w_raw;
  logic [PW-1:0] r_phase_cnt, w_phase_cnt_nx;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic r_phase, w_phase_nx, w_clr, w_tick, w_last, w_pwm_on;
  assign w_chg    = led_word_in ^ r_word_q;
  assign w_last   = r_phase_cnt == LAST;
  assign w_raw    = (r_mask & {LED_W{r_phase}}) | (r_word_q & ~r_mask);
  assign w_pwm_on = (duty == '1) | (r_pwm_cnt < duty);
  snake_led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );
  // Next state: any change (re)starts the flash and outranks a coincident final tick
  always_comb begin
    w_state_nx     = r_state;
    w_mask_nx      = r_mask;
    w_phase_nx     = r_phase;
    w_phase_cnt_nx = r_phase_cnt;
    w_clr          = 1'b0;
    if (w_chg != '0) begin
      w_state_nx     = ST_FLASH;
      w_mask_nx      = r_mask | w_chg;
      w_phase_nx     = 1'b1;
      w_phase_cnt_nx = '0;
      w_clr          = 1'b1;
    end else if (r_state == ST_FLASH && w_tick) begin
      w_state_nx     = w_last ? ST_IDLE : ST_FLASH;
      w_mask_nx      = w_last ? '0 : r_mask;
      w_phase_nx     = ~r_phase;
      w_phase_cnt_nx = w_last ? '0 : r_phase_cnt + PW'(1);
    end
  end
  // Input capture, FSM state and free-running PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_q    <= '0;
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_phase     <= 1'b0;
      r_phase_cnt <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      r_word_q    <= led_word_in;
      r_state     <= w_state_nx;
      r_mask      <= w_mask_nx;
      r_phase     <= w_phase_nx;
      r_phase_cnt <= w_phase_cnt_nx;
      r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
    end
  end
  // Registered pin drive: blink pattern gated by PWM, flashing follows the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out  <= '0;
      flashing <= 1'b0;
    end else begin
      led_out  <= w_raw & {LED_W{w_pwm_on}};
      flashing <= w_state_nx == ST_FLASH;
    end
  end
endmodule

// File: tb/tb_snake_led_fx.sv
// tb_snake_led_fx: scoreboard bench for the LED blink/PWM block with hand-derived schedules
module tb_snake_led_fx;
  localparam int TD = 4;
  localparam int NB = 2;
  localparam int LEN = 2 * NB * TD;
  typedef struct {
    int         cyc;
    logic [9:0] led;
    logic       fl;
    bit         chk_led;
    string      name;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] led_word_in = '0;
  logic [3:0] duty = 4'hF;
  logic [9:0] led_out;
  logic flashing;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rel = 0;

  snake_led_fx #(.LED_W(10), .TICK_DIV(TD), .BLINKS(NB), .PWM_BITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .led_word_in (led_word_in),
    .duty        (duty),
    .led_out     (led_out),
    .flashing    (flashing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [9:0] led, input logic fl, input bit cl, input string nm);
    exp_t e;
    e.cyc = c;
    e.led = led;
    e.fl = fl;
    e.chk_led = cl;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Change seen in window k: flashing high for samples k+1..k+LEN, blink shows from k+2,
  // alternating every TD samples starting on, then the new word from k+LEN+2.
  task automatic expect_flash(input int k, input logic [9:0] m, input logic [9:0] w, input int tmax, input string nm);
    logic [9:0] led;
    for (int t = 1; t <= tmax; t++) begin
      if (t == 1) led = '0;
      else if (t <= LEN + 1) led = (((t - 2) / TD) % 2 == 0) ? (m | (w & ~m)) : (w & ~m);
      else led = w;
      push(k + t, led, t <= LEN, t >= 2, nm);
    end
  endtask

  task automatic settle(input logic [9:0] w);
    led_word_in = w;
    step(LEN + 4);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (e.cyc < cyc)
        $display("FAIL %s cyc %0d: sample missed at cyc %0d", e.name, e.cyc, cyc);
      else if (flashing !== e.fl || (e.chk_led && led_out !== e.led))
        $display("FAIL %s cyc %0d: got led_out=%h flashing=%b, want led_out=%h flashing=%b%s",
                 e.name, cyc, led_out, flashing, e.led, e.fl, e.chk_led ? "" : " (led not checked)");
      else n_pass++;
    end
  end

  initial begin
    led_word_in = 10'h3FF;
    step(1);
    for (int i = 0; i < 3; i++) push(cyc + i, '0, 1'b0, 1'b1, "reset_hold");
    step(3);
    reset_n = 1'b1;
    rel = cyc;
    expect_flash(cyc, 10'h3FF, 10'h3FF, LEN + 2, "reset_release");
    step(LEN + 4);

    settle(10'h000);
    led_word_in = 10'h001;
    expect_flash(cyc, 10'h001, 10'h001, LEN + 2, "single");
    step(LEN + 4);

    settle(10'h000);
    led_word_in = 10'h001;
    expect_flash(cyc, 10'h001, 10'h001, 6, "restart_a");
    step(6);
    led_word_in = 10'h003;
    expect_flash(cyc, 10'h003, 10'h003, LEN + 2, "restart_b");
    step(LEN + 4);

    settle(10'h000);
    led_word_in = 10'h001;
    expect_flash(cyc, 10'h001, 10'h001, LEN, "simul_a");
    step(LEN);
    led_word_in = 10'h003;
    expect_flash(cyc, 10'h003, 10'h003, LEN + 2, "simul_b");
    step(LEN + 4);

    settle(10'h2AA);
    duty = 4'd4;
    for (int s = cyc + 1; s <= cyc + 16; s++)
      push(s, (((s - 1 - rel) % 16) < 4) ? 10'h2AA : 10'h000, 1'b0, 1'b1, "pwm4");
    step(16);
    duty = 4'd0;
    for (int s = cyc + 1; s <= cyc + 16; s++) push(s, 10'h000, 1'b0, 1'b1, "pwm0");
    step(16);
    duty = 4'hF;
    for (int s = cyc + 1; s <= cyc + 16; s++) push(s, 10'h2AA, 1'b0, 1'b1, "pwm15");
    step(16);

    led_word_in = 10'h155;
    expect_flash(cyc, 10'h3FF, 10'h155, 4, "midflash_pre");
    step(5);
    reset_n = 1'b0;
    push(cyc, '0, 1'b0, 1'b1, "async_reset");
    step(1);
    push(cyc, '0, 1'b0, 1'b1, "reset_low");
    reset_n = 1'b1;
    expect_flash(cyc, 10'h155, 10'h155, LEN + 2, "post_reset");
    step(LEN + 4);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
